// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART block controller.
// Blocks are byte-addressed MSB first: byte 0 occupies the top eight bits.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        RX,
        CORE_REQ,
        CORE_WAIT,
        TX_ARM,
        TX_PULSE,
        TX_WAIT
    } ctrl_state_t;

    localparam int DEF_BYTES   = 8;
    localparam int DEF_TIMEOUT = 2_000_000;

    // LSB position of byte idx within an nbytes-wide block
    function automatic int byte_lsb(input int idx, input int nbytes);
        return 8 * (nbytes - 1 - idx);
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer: restarts on load, sits at zero while disabled,
// saturates instead of wrapping, and flags expiry after TIMEOUT idle cycles.
module uart_idle_timer
    import uart_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] SAT   = TW'(TIMEOUT);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load || !en) begin
            count <= '0;
        end else if (count != SAT) begin
            count <= count + TW'(1);
        end
    end

    // A byte arriving in the expiry cycle takes priority over the discard
    assign expire = en && !load && (count == LIMIT);

endmodule

// File: rtl/uart_block_ctrl.sv
// Collects BYTES UART bytes into a block for the cipher core, then streams
// the core's result back out through the transmitter's start/tx_rdy handshake.
module uart_block_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int BYTES   = DEF_BYTES,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_done,
    input  logic               tx_rdy,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    output logic [8*BYTES-1:0] blk_out,
    output logic               blk_valid,
    input  logic               blk_ready,
    input  logic [8*BYTES-1:0] res_in,
    input  logic               res_valid,
    output logic               res_ready,
    output logic               busy,
    output logic               err_timeout,
    output logic               err_overrun
);
    localparam int CW = $clog2(BYTES);
    localparam int W  = 8 * BYTES;
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

    ctrl_state_t   state, state_nxt;
    logic [CW-1:0] cnt, idx;
    logic [W-1:0]  asm_q, asm_nxt, res_q;
    logic          take_byte, timer_en, expire;

    uart_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (take_byte),
        .en     (timer_en),
        .expire (expire)
    );

    assign timer_en = (state == RX) && (cnt != '0);

    always_comb begin
        state_nxt = state;
        take_byte = 1'b0;
        asm_nxt   = asm_q;
        asm_nxt[byte_lsb(int'(cnt), BYTES) +: 8] = rx_data;
        case (state)
            RX: begin
                if (rx_done) begin
                    take_byte = 1'b1;
                    if (cnt == LAST) state_nxt = CORE_REQ;
                end
            end
            CORE_REQ:  if (blk_valid && blk_ready) state_nxt = CORE_WAIT;
            CORE_WAIT: if (res_valid && res_ready) state_nxt = TX_ARM;
            TX_ARM:    if (tx_rdy)  state_nxt = TX_PULSE;
            TX_PULSE:  if (!tx_rdy) state_nxt = TX_WAIT;
            TX_WAIT:   if (tx_rdy)  state_nxt = (idx == LAST) ? RX : TX_ARM;
            default:   state_nxt = RX;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RX;
            cnt         <= '0;
            idx         <= '0;
            asm_q       <= '0;
            res_q       <= '0;
            blk_out     <= '0;
            blk_valid   <= 1'b0;
            res_ready   <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            blk_valid   <= (state_nxt == CORE_REQ);
            res_ready   <= (state_nxt == CORE_WAIT);
            tx_start    <= (state_nxt == TX_PULSE);
            busy        <= (state_nxt != RX);
            err_overrun <= rx_done && (state != RX);
            err_timeout <= 1'b0;

            if (take_byte) begin
                asm_q <= asm_nxt;
                if (cnt == LAST) begin
                    cnt     <= '0;
                    blk_out <= asm_nxt;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (expire) begin
                cnt         <= '0;
                err_timeout <= 1'b1;
            end

            if (state == CORE_WAIT && res_valid) begin
                res_q   <= res_in;
                idx     <= '0;
                tx_data <= res_in[byte_lsb(0, BYTES) +: 8];
            end

            if (state == TX_WAIT && tx_rdy && idx != LAST) begin
                idx     <= idx + CW'(1);
                tx_data <= res_q[byte_lsb(int'(idx) + 1, BYTES) +: 8];
            end
        end
    end

endmodule

// File: tb/tb_uart_block_ctrl.sv
// Bench for uart_block_ctrl: table-driven block transfers, timeout, overrun
// and reset sequences, then random byte streams against a queue-based model.
module tb_uart_block_ctrl;
    localparam int NB = 8;
    localparam int TO = 100;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      rx_data;
    logic            rx_done;
    logic            tx_rdy;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic [8*NB-1:0] blk_out;
    logic            blk_valid;
    logic            blk_ready;
    logic [8*NB-1:0] res_in;
    logic            res_valid;
    logic            res_ready;
    logic            busy;
    logic            err_timeout;
    logic            err_overrun;

    int checks = 0, failures = 0;
    int n_to = 0, n_ovr = 0;
    int tx_gap = 50;
    logic [7:0]  tx_q[$];
    logic [63:0] blk_q[$];
    logic        st_prev = 1'b0;

    typedef struct {
        logic [63:0] blk;
        logic [63:0] res;
        int          gap;
        int          rdy_dly;
        int          res_dly;
        bit          ovr;
        logic [63:0] exp_blk;
        logic [63:0] exp_tx;
        int          exp_ovr;
    } vec_t;
    vec_t vt[4];

    always #5 clk = ~clk;

    uart_block_ctrl #(.BYTES(NB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .tx_rdy(tx_rdy), .tx_start(tx_start), .tx_data(tx_data),
        .blk_out(blk_out), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .res_in(res_in), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    // Transmitter: latches two cycles after a start edge, idle again tx_gap later
    initial begin
        tx_rdy = 1'b1;
        forever begin
            @(posedge tx_start);
            repeat (2) @(posedge clk);
            #1 tx_rdy = 1'b0;
            repeat (tx_gap) @(posedge clk);
            #1 tx_rdy = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (tx_start && !st_prev) tx_q.push_back(tx_data);
        st_prev = tx_start;
        if (err_overrun) n_ovr++;
        if (err_timeout) n_to++;
        if (blk_valid && blk_ready) blk_q.push_back(blk_out);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
    endtask

    task automatic give_res(input logic [63:0] r, input int dly);
        tick(dly);
        res_in    = r;
        res_valid = 1'b1;
        tick(1);
        res_valid = 1'b0;
    endtask

    task automatic drain_tx(input logic [63:0] r);
        bit ok;
        logic [63:0] got;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check("tx_done_in_time", 64'(ok), 64'd1);
        got = '0;
        foreach (tx_q[i]) got = {got[55:0], tx_q[i]};
        check("tx_edge_count", 64'(tx_q.size()), 64'(NB));
        check("tx_byte_stream", got, r);
    endtask

    task automatic run_block(input vec_t v);
        int n0;
        bit held;
        tx_q.delete();
        blk_q.delete();
        n0 = n_ovr;
        blk_ready = (v.rdy_dly == 0);
        for (int i = 0; i < NB; i++) begin
            send_byte(v.blk[63 - 8*i -: 8]);
            if (i < NB - 1) tick(v.gap);
        end
        check("blk_valid_rise", 64'(blk_valid), 64'd1);
        check("blk_out_value", blk_out, v.exp_blk);
        check("busy_in_block", 64'(busy), 64'd1);
        held = 1'b1;
        for (int j = 0; j < v.rdy_dly; j++) begin
            tick(1);
            if (blk_valid !== 1'b1 || blk_out !== v.exp_blk) held = 1'b0;
        end
        check("blk_held_stable", 64'(held), 64'd1);
        blk_ready = 1'b1;
        tick(1);
        blk_ready = 1'b0;
        check("blk_valid_drop", 64'(blk_valid), 64'd0);
        check("blk_handshakes", 64'(blk_q.size()), 64'd1);
        check("res_ready_up", 64'(res_ready), 64'd1);
        if (v.ovr) begin
            tick(1);
            send_byte(8'hEE);
            check("overrun_core_wait", 64'(err_overrun), 64'd1);
        end
        give_res(v.res, v.res_dly);
        check("res_ready_drop", 64'(res_ready), 64'd0);
        if (v.ovr) begin
            for (int k = 0; k < 100 && tx_rdy; k++) tick(1);
            tick(3);
            send_byte(8'h77);
            check("overrun_tx_wait", 64'(err_overrun), 64'd1);
        end
        drain_tx(v.exp_tx);
        check("overrun_pulses", 64'(n_ovr - n0), 64'(v.exp_ovr));
        tick(2);
    endtask

    initial begin
        int   t0, k_hit, n_hit;
        bit   ok;
        logic [7:0]  b;
        logic [7:0]  mq[$];
        logic [63:0] exp_blk, r, got;
        int   exp_to, g;

        vt[0] = '{64'h0102030405060708, 64'hA1B2C3D4E5F60718, 0, 0, 0, 1'b0,
                  64'h0102030405060708, 64'hA1B2C3D4E5F60718, 0};
        vt[1] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 2, 20, 3, 1'b0,
                  64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 0};
        vt[2] = '{64'hDEADBEEFCAFEF00D, 64'h1122334455667788, 0, 1, 5, 1'b1,
                  64'hDEADBEEFCAFEF00D, 64'h1122334455667788, 2};
        vt[3] = '{64'hFF00FF0000FF00FF, 64'h0000000000000080, 7, 0, 0, 1'b0,
                  64'hFF00FF0000FF00FF, 64'h0000000000000080, 0};

        rst = 1'b0; rx_data = '0; rx_done = 1'b0; blk_ready = 1'b0;
        res_in = '0; res_valid = 1'b0;
        tick(3);
        check("reset_ctrl_outs", {50'd0, tx_start, tx_data, blk_valid, res_ready,
                                  busy, err_timeout, err_overrun}, 64'd0);
        check("reset_blk_out", blk_out, 64'd0);
        rst = 1'b1;
        tick(2);

        run_block(vt[0]);

        // Partial block of three, then silence: discard exactly TO cycles later
        t0 = n_to;
        for (int i = 0; i < 3; i++) send_byte(8'h10 + 8'(i));
        k_hit = -1;
        n_hit = 0;
        for (int k = 1; k <= TO + 10; k++) begin
            tick(1);
            if (err_timeout) begin
                n_hit++;
                if (k_hit < 0) k_hit = k;
            end
        end
        check("timeout_cycle", 64'(k_hit), 64'(TO));
        check("timeout_pulses", 64'(n_hit), 64'd1);
        check("timeout_not_busy", 64'(busy), 64'd0);
        // A byte landing on the expiry cycle wins and restarts the timer
        send_byte(8'h55);
        tick(TO - 1);
        send_byte(8'h66);
        check("timeout_vs_byte", 64'(err_timeout), 64'd0);
        tick(TO + 5);
        check("timeout_after_restart", 64'(n_to - t0), 64'd2);

        for (int i = 0; i < 4; i++) run_block(vt[i]);

        // Reset while waiting on the fifth byte's transmission
        blk_ready = 1'b1;
        tx_q.delete();
        for (int i = 0; i < NB; i++) send_byte(8'h30 + 8'(i));
        tick(1);
        give_res(64'h0F1E2D3C4B5A6978, 0);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (tx_q.size() >= 5 && !tx_rdy) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check("reached_tx_wait_idx4", 64'(ok), 64'd1);
        tick(2);
        #2 rst = 1'b0;
        #1;
        check("async_reset_ctrl", {50'd0, tx_start, tx_data, blk_valid, res_ready,
                                   busy, err_timeout, err_overrun}, 64'd0);
        check("async_reset_blk", blk_out, 64'd0);
        tick(2);
        rst = 1'b1;
        tick(60);
        run_block(vt[1]);

        // Random streams; the model keeps only bytes since the last discard
        for (int rr = 0; rr < 6; rr++) begin
            mq.delete();
            exp_to = n_to;
            blk_ready = 1'b1;
            blk_q.delete();
            tx_q.delete();
            while (mq.size() < NB) begin
                if (mq.size() > 0) begin
                    if ($urandom_range(0, 9) == 0) begin
                        g = $urandom_range(TO + 1, TO + 30);
                        mq.delete();
                        exp_to++;
                    end else begin
                        g = $urandom_range(0, 20);
                    end
                    tick(g);
                end
                b = 8'($urandom);
                send_byte(b);
                mq.push_back(b);
            end
            exp_blk = '0;
            foreach (mq[i]) exp_blk = {exp_blk[55:0], mq[i]};
            tick(1);
            got = (blk_q.size() == 1) ? blk_q[0] : ~exp_blk;
            check("rnd_block", got, exp_blk);
            check("rnd_timeouts", 64'(n_to), 64'(exp_to));
            r = {$urandom, $urandom};
            give_res(r, $urandom_range(0, 6));
            drain_tx(r);
            tick(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
